cpumc: RTL and testbench

CPU memory controller for the NES core. It sits directly downstream of the 2A03 block and consumes that block's muxed CPU bus (address, write data, read/write select). It decodes the address into 2 KB internal work RAM (mirrored), optional 8 KB PRG-RAM, and PRG-ROM, and returns registered read data. It also provides a host loader port that fills PRG-ROM while the CPU is held off the bus.

---
 rtl/cpumc.sv | 59 +++++
 tb/tb_cpumc.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/cpumc.sv
// cpumc: NES CPU memory controller decoding WRAM, PRG-RAM and PRG-ROM with a host PRG-ROM loader.
module cpumc #(
  parameter int PRG_ROM_AW = 15,
  parameter bit PRG_RAM_EN = 1'b1
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [15:0]           a_in,
  input  logic [7:0]            d_in,
  input  logic                  r_nw_in,
  output logic [7:0]            d_out,
  input  logic                  ld_en_in,
  input  logic                  ld_start_in,
  input  logic                  ld_wr_in,
  input  logic [7:0]            ld_d_in,
  output logic [PRG_ROM_AW-1:0] ld_addr_out,
  output logic                  ld_full_out
);
  typedef enum logic {RUN, LOAD} mode_t;
  mode_t state;
  logic [7:0] wram [2048];
  logic [7:0] pram [8192];
  logic [7:0] rom [2**PRG_ROM_AW];
  logic wram_sel, pram_sel, rom_sel, run, cpu_wr, ld_wr;
  logic [PRG_ROM_AW-1:0] ld_ptr;
  assign wram_sel = a_in[15:13] == 3'b000;
  assign pram_sel = PRG_RAM_EN && a_in[15:13] == 3'b011;
  assign rom_sel = a_in[15];
  assign run = state == RUN;
  assign cpu_wr = run && !r_nw_in;
  assign ld_wr = !run && ld_wr_in;
  // a start pulse coinciding with a strobe writes at address 0
  assign ld_ptr = ld_start_in ? '0 : ld_addr_out;
  always_ff @(posedge clk_in)
    if (cpu_wr && wram_sel) wram[a_in[10:0]] <= d_in;
  always_ff @(posedge clk_in)
    if (cpu_wr && pram_sel) pram[a_in[12:0]] <= d_in;
  always_ff @(posedge clk_in)
    if (ld_wr) rom[ld_ptr] <= ld_d_in;
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      state <= RUN;
      d_out <= '0;
      ld_addr_out <= '0;
      ld_full_out <= 1'b0;
    end else begin
      state <= ld_en_in ? LOAD : RUN;
      d_out <= (!run || !r_nw_in) ? '0 :
               wram_sel ? wram[a_in[10:0]] :
               pram_sel ? pram[a_in[12:0]] :
               rom_sel ? rom[a_in[PRG_ROM_AW-1:0]] : '0;
      if (!run) begin
        if (ld_wr_in) ld_addr_out <= ld_ptr + 1'b1;
        else if (ld_start_in) ld_addr_out <= '0;
        if (ld_start_in) ld_full_out <= 1'b0;
        else if (ld_wr_in && &ld_addr_out) ld_full_out <= 1'b1;
      end
    end
endmodule

// File: tb/tb_cpumc.sv
// tb_cpumc: randomized self-checking bench for cpumc against a flat-array reference model.
module tb_cpumc;
  localparam int AW = 14;
  localparam int RSZ = 1 << AW;
  logic clk_in = 1'b0, rst_in = 1'b0;
  logic [15:0] a_in = 16'h2000;
  logic [7:0] d_in = '0, ld_d_in = '0;
  logic r_nw_in = 1'b1, ld_en_in = 1'b0, ld_start_in = 1'b0, ld_wr_in = 1'b0;
  logic [7:0] d_out;
  logic [AW-1:0] ld_addr_out;
  logic ld_full_out;
  cpumc #(.PRG_ROM_AW(AW), .PRG_RAM_EN(1'b1)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .a_in(a_in), .d_in(d_in), .r_nw_in(r_nw_in),
    .d_out(d_out), .ld_en_in(ld_en_in), .ld_start_in(ld_start_in), .ld_wr_in(ld_wr_in),
    .ld_d_in(ld_d_in), .ld_addr_out(ld_addr_out), .ld_full_out(ld_full_out)
  );
  always #5 clk_in = ~clk_in;
  int errors = 0, checks = 0;
  logic [7:0] m_wram [2048];
  logic [7:0] m_pram [8192];
  logic [7:0] m_rom [RSZ];
  bit v_wram [2048];
  bit v_pram [8192];
  bit v_rom [RSZ];
  bit m_load = 0, m_full = 0;
  int m_ptr = 0;
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // one clock: predict from the current inputs, clock, then compare
  task automatic cyc(input string tag);
    int a, exp_d;
    bit known;
    a = int'(a_in);
    exp_d = 0;
    known = 1;
    if (!m_load) begin
      if (r_nw_in) begin
        if (a < 'h2000) begin exp_d = int'(m_wram[a % 2048]); known = v_wram[a % 2048]; end
        else if (a >= 'h6000 && a < 'h8000) begin exp_d = int'(m_pram[a - 'h6000]); known = v_pram[a - 'h6000]; end
        else if (a >= 'h8000) begin exp_d = int'(m_rom[(a - 'h8000) % RSZ]); known = v_rom[(a - 'h8000) % RSZ]; end
      end else if (a < 'h2000) begin
        m_wram[a % 2048] = d_in; v_wram[a % 2048] = 1;
      end else if (a >= 'h6000 && a < 'h8000) begin
        m_pram[a - 'h6000] = d_in; v_pram[a - 'h6000] = 1;
      end
    end else begin
      if (ld_start_in) begin m_ptr = 0; m_full = 0; end
      if (ld_wr_in) begin
        m_rom[m_ptr] = ld_d_in; v_rom[m_ptr] = 1;
        if (m_ptr == RSZ - 1) m_full = 1;
        m_ptr = (m_ptr + 1) % RSZ;
      end
    end
    m_load = ld_en_in;
    @(posedge clk_in); #1;
    if (known) check({tag, "/d_out"}, int'(d_out), exp_d);
    check({tag, "/ld_addr"}, int'(ld_addr_out), m_ptr);
    check({tag, "/ld_full"}, int'(ld_full_out), int'(m_full));
  endtask
  task automatic cpu(input int a, input int d, input bit rnw, input string tag);
    a_in = 16'(a); d_in = 8'(d); r_nw_in = rnw;
    cyc(tag);
  endtask
  task automatic do_reset(input string tag);
    #2 rst_in = 1'b1;
    #1;
    check({tag, "/d_out"}, int'(d_out), 0);
    check({tag, "/ld_addr"}, int'(ld_addr_out), 0);
    check({tag, "/ld_full"}, int'(ld_full_out), 0);
    m_load = 0; m_ptr = 0; m_full = 0;
    @(negedge clk_in);
    rst_in = 1'b0;
  endtask
  task automatic strobes(input int n, input string tag);
    ld_wr_in = 1'b1;
    for (int i = 0; i < n; i++) begin ld_d_in = 8'($urandom); cyc(tag); end
    ld_wr_in = 1'b0;
  endtask
  task automatic ld_start(input string tag);
    ld_start_in = 1'b1; cyc(tag); ld_start_in = 1'b0;
  endtask
  initial begin
    logic [7:0] prog [4];
    prog[0] = 8'hA9; prog[1] = 8'h01; prog[2] = 8'h8D; prog[3] = 8'h00;
    do_reset("rst0");
    cpu('h0005, 'h5A, 0, "mir_wr");
    check("mir_wr_d0", int'(d_out), 0);
    cpu('h0805, 0, 1, "mir1");
    check("mir1_val", int'(d_out), 'h5A);
    cpu('h1005, 0, 1, "mir2");
    cpu('h1805, 0, 1, "mir3");
    check("mir3_val", int'(d_out), 'h5A);
    ld_en_in = 1'b1; ld_wr_in = 1'b1; ld_d_in = 8'hEE;
    cpu('h0005, 0, 1, "ld_rise");
    check("ld_rise_ptr", int'(ld_addr_out), 0);
    ld_wr_in = 1'b0;
    ld_start("ld_start");
    ld_wr_in = 1'b1;
    for (int i = 0; i < 4; i++) begin ld_d_in = prog[i]; cyc("ld_byte"); end
    ld_wr_in = 1'b0;
    check("ld_ptr4", int'(ld_addr_out), 4);
    ld_en_in = 1'b0;
    cpu('h0005, 'h11, 0, "ld_fall_wr");
    cpu('h0005, 0, 1, "ld_fall_chk");
    check("ld_fall_ignored", int'(d_out), 'h5A);
    for (int i = 0; i < 4; i++) begin
      cpu('h8000 + i, 0, 1, "rom_rd");
      check("rom_rd_val", int'(d_out), int'(prog[i]));
    end
    cpu('hC000, 0, 1, "rom_mirror");
    check("rom_mirror_val", int'(d_out), 'hA9);
    cpu('h2000, 'hFF, 0, "unm_wr");
    cpu('h8000, 'hFF, 0, "rom_wr");
    check("rom_wr_d0", int'(d_out), 0);
    cpu('h2000, 0, 1, "unm_rd");
    check("unm_rd_val", int'(d_out), 0);
    cpu('h8000, 0, 1, "rom_prot");
    check("rom_prot_val", int'(d_out), 'hA9);
    cpu('h7FFF, 'h3C, 0, "pram_wr");
    cpu('h7FFF, 0, 1, "pram_rd");
    check("pram_rd_val", int'(d_out), 'h3C);
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 3);
      a_in = r == 0 ? 16'($urandom_range(0, 15) + 'h800 * $urandom_range(0, 3)) :
             r == 1 ? 16'('h6000 + $urandom_range(0, 15)) :
             r == 2 ? 16'('h8000 + $urandom_range(0, 15) + 'h4000 * $urandom_range(0, 1)) :
                      16'('h2000 + $urandom_range(0, 'h3FFF));
      d_in = 8'($urandom);
      r_nw_in = 1'($urandom);
      if ($urandom_range(0, 19) == 0) ld_en_in = ~ld_en_in;
      ld_start_in = $urandom_range(0, 29) == 0;
      ld_wr_in = 1'($urandom);
      ld_d_in = 8'($urandom);
      cyc("rand");
    end
    ld_start_in = 1'b0; ld_wr_in = 1'b0; r_nw_in = 1'b1; a_in = 16'h2000;
    ld_en_in = 1'b0;
    cyc("rand_exit");
    ld_en_in = 1'b1;
    cyc("wrap_en");
    ld_start("wrap_start");
    strobes(RSZ, "wrap");
    check("wrap_ptr", int'(ld_addr_out), 0);
    check("wrap_full", int'(ld_full_out), 1);
    ld_wr_in = 1'b1; ld_d_in = 8'h42; cyc("wrap_over"); ld_wr_in = 1'b0;
    check("wrap_over_full", int'(ld_full_out), 1);
    ld_start("wrap_clr");
    check("wrap_clr_full", int'(ld_full_out), 0);
    strobes('h123, "sim_fill");
    check("sim_ptr123", int'(ld_addr_out), 'h123);
    ld_start_in = 1'b1; ld_wr_in = 1'b1; ld_d_in = 8'h77;
    cyc("sim");
    ld_start_in = 1'b0; ld_wr_in = 1'b0;
    check("sim_ptr", int'(ld_addr_out), 1);
    check("sim_full", int'(ld_full_out), 0);
    ld_en_in = 1'b0;
    cyc("sim_exit");
    cpu('h8000, 0, 1, "sim_rd");
    check("sim_rd_val", int'(d_out), 'h77);
    cpu('h0005, 'h5A, 0, "mid_wr");
    ld_en_in = 1'b1;
    cyc("mid_en");
    ld_start("mid_start");
    strobes('h40, "mid_fill");
    ld_en_in = 1'b0;
    cyc("mid_exit");
    ld_en_in = 1'b1;
    cpu('h0005, 0, 1, "mid_rd");
    check("mid_d5a", int'(d_out), 'h5A);
    check("mid_ptr40", int'(ld_addr_out), 'h40);
    do_reset("rst_mid");
    ld_en_in = 1'b0;
    cpu('h8001, 0, 1, "post_rst_rd");
    cpu('h8002, 0, 1, "post_rst_rd2");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
